// File: rtl/mux_pkg.sv
// Shared defaults for the registered N:1 select and its error counter.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
//
// Contents:
//   DATA_W_DFLT / N_IN_DFLT / SEL_W_DFLT : default sizing of mux_reg_n
//   ERR_CNT_W / ERR_CNT_MAX              : width and saturation value of err_cnt
//   sat_inc()                            : saturating increment for err_cnt
package mux_pkg;

   localparam int DATA_W_DFLT = 64;
   localparam int N_IN_DFLT   = 4;
   localparam int SEL_W_DFLT  = 4;

   localparam int                   ERR_CNT_W   = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Count up by one, parking at ERR_CNT_MAX instead of wrapping to zero.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == ERR_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N_IN:1 word select; out-of-range indices yield DFLT.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
//
// Ports:
//   in_data  [N_IN*DATA_W]  flattened words, word k at [k*DATA_W +: DATA_W]
//   sel      [SEL_W]        word index
//   dat      [DATA_W]       selected word, or DFLT when sel >= N_IN
//   in_range [1]            high when sel < N_IN
module mux_n
   import mux_pkg::*;
#(
   parameter int                DATA_W = DATA_W_DFLT,
   parameter int                N_IN   = N_IN_DFLT,
   parameter int                SEL_W  = SEL_W_DFLT,
   parameter logic [DATA_W-1:0] DFLT   = '0
) (
   input  logic [N_IN*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]       sel,
   output logic [DATA_W-1:0]      dat,
   output logic                   in_range
);

   // Defaults cover every sel value that matches no input, so the
   // out-of-range case needs no explicit branch and no latch can form.
   always_comb begin
      dat      = DFLT;
      in_range = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            dat      = in_data[k*DATA_W +: DATA_W];
            in_range = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_reg_n.sv
// Registered N_IN:1 select with valid/ready handshake and out-of-range select tracking.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
// Backpressure: single output register; in_ready = !out_valid || out_ready, full throughput.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset (dominates all inputs)
//   in_data, sel          flattened input words and word index, captured on accept
//   in_valid / in_ready   input handshake
//   out_data, out_sel     registered selected word and the sel that produced it
//   out_valid / out_ready output handshake
//   sel_err               sticky: an out-of-range sel has been accepted
//   err_clr               clears sel_err and err_cnt (a simultaneous error wins)
//   err_cnt               saturating count of accepted out-of-range selects
module mux_reg_n
   import mux_pkg::*;
#(
   parameter int                DATA_W = DATA_W_DFLT,
   parameter int                N_IN   = N_IN_DFLT,   // legal 2..16
   parameter int                SEL_W  = SEL_W_DFLT,  // needs 2**SEL_W >= N_IN
   parameter logic [DATA_W-1:0] DFLT   = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_IN*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]       sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [SEL_W-1:0]       out_sel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   sel_err,
   input  logic                   err_clr,
   output logic [ERR_CNT_W-1:0]   err_cnt
);

   logic              accept;
   logic              xfer_out;
   logic [DATA_W-1:0] mux_dat;
   logic              mux_in_range;

   // Register is free when empty or being drained this same cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer_out = out_valid && out_ready;

   mux_n #(
      .DATA_W (DATA_W),
      .N_IN   (N_IN),
      .SEL_W  (SEL_W),
      .DFLT   (DFLT)
   ) u_mux_n (
      .in_data  (in_data),
      .sel      (sel),
      .dat      (mux_dat),
      .in_range (mux_in_range)
   );

   // Output stage. data/sel only move on accept, so an idle or stalled
   // producer never disturbs the held word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= mux_dat;
         out_sel   <= sel;
      end else if (xfer_out) begin
         out_valid <= 1'b0;
      end
   end

   // Error tracking. An out-of-range accept in the same cycle as err_clr
   // restarts the count at one rather than being lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err <= 1'b0;
         err_cnt <= '0;
      end else if (accept && !mux_in_range) begin
         sel_err <= 1'b1;
         err_cnt <= err_clr ? ERR_CNT_W'(1) : sat_inc(err_cnt);
      end else if (err_clr) begin
         sel_err <= 1'b0;
         err_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_mux_reg_n.sv
module tb_mux_reg_n;

   localparam int DW = 64;
   localparam int NI = 4;
   localparam int SW = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NI*DW-1:0]  in_data;
   logic [SW-1:0]     sel;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     out_data;
   logic [SW-1:0]     out_sel;
   logic              out_valid;
   logic              out_ready;
   logic              sel_err;
   logic              err_clr;
   logic [7:0]        err_cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mux_reg_n #(.DATA_W(DW), .N_IN(NI), .SEL_W(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel_err   (sel_err),
      .err_clr   (err_clr),
      .err_cnt   (err_cnt)
   );

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input logic [DW-1:0] w2, input logic [DW-1:0] w3);
      in_data = {w3, w2, w1, w0};
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; sel = '0;
      set_words(64'h1, 64'h2, 64'h3, 64'h4);
      tick(); tick();
      reset = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
      vectors++; if (out_data !== 64'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
      vectors++; if (out_sel !== 4'h0) begin miscompares++; $display("FAIL reset_out_sel got %h want 0", out_sel); end
      vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL reset_sel_err got %h want 0", sel_err); end
      vectors++; if (err_cnt !== 8'h0) begin miscompares++; $display("FAIL reset_err_cnt got %h want 0", err_cnt); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %h want 1", in_ready); end
   endtask

   task automatic test_basic();
      set_words(64'hA0, 64'hA1, 64'hDEAD_BEEF, 64'hA3);
      sel = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %h want 1", out_valid); end
      vectors++; if (out_data !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL basic_out_data got %h want deadbeef", out_data); end
      vectors++; if (out_sel !== 4'd2) begin miscompares++; $display("FAIL basic_out_sel got %h want 2", out_sel); end
      // drain with no new accept: valid drops, data/sel hold
      sel = 4'd1;
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_out_valid got %h want 0", out_valid); end
      vectors++; if (out_data !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL drain_hold_data got %h want deadbeef", out_data); end
      vectors++; if (out_sel !== 4'd2) begin miscompares++; $display("FAIL drain_hold_sel got %h want 2", out_sel); end
   endtask

   task automatic test_back_to_back();
      set_words(64'd10, 64'd11, 64'd12, 64'd13);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sel = SW'(i); in_valid = 1'b1;
         #1;
         vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d] got %h want 1", i, in_ready); end
         tick();
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_out_valid[%0d] got %h want 1", i, out_valid); end
         vectors++; if (out_data !== 64'(10 + i)) begin miscompares++; $display("FAIL b2b_out_data[%0d] got %0d want %0d", i, out_data, 10 + i); end
         vectors++; if (out_sel !== SW'(i)) begin miscompares++; $display("FAIL b2b_out_sel[%0d] got %0d want %0d", i, out_sel, i); end
      end
      in_valid = 1'b0;
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end_valid got %h want 0", out_valid); end
   endtask

   task automatic test_stall();
      set_words(64'd99, 64'd5, 64'd7, 64'd8);
      sel = 4'd1; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      vectors++; if (out_data !== 64'd5) begin miscompares++; $display("FAIL stall_load got %0d want 5", out_data); end
      // keep offering word 0 while the consumer stalls
      sel = 4'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d] got %h want 0", i, in_ready); end
         tick();
         vectors++; if (out_data !== 64'd5) begin miscompares++; $display("FAIL stall_data[%0d] got %0d want 5", i, out_data); end
         vectors++; if (out_sel !== 4'd1) begin miscompares++; $display("FAIL stall_sel[%0d] got %0d want 1", i, out_sel); end
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got %h want 1", i, out_valid); end
      end
      out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_rdy got %h want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      vectors++; if (out_data !== 64'd99) begin miscompares++; $display("FAIL stall_resume_data got %0d want 99", out_data); end
      vectors++; if (out_sel !== 4'd0) begin miscompares++; $display("FAIL stall_resume_sel got %0d want 0", out_sel); end
      tick();
   endtask

   task automatic test_out_of_range();
      set_words(64'hF0, 64'hF1, 64'hF2, 64'hF3);
      out_ready = 1'b1;
      sel = 4'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++; if (out_data !== 64'h0) begin miscompares++; $display("FAIL oor_dflt got %h want 0", out_data); end
      vectors++; if (out_sel !== 4'd7) begin miscompares++; $display("FAIL oor_sel got %0d want 7", out_sel); end
      vectors++; if (sel_err !== 1'b1) begin miscompares++; $display("FAIL oor_sel_err got %h want 1", sel_err); end
      vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL oor_err_cnt got %0d want 1", err_cnt); end
      // out-of-range sel without accept is ignored
      sel = 4'd9;
      tick();
      vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL oor_no_accept got %0d want 1", err_cnt); end
      // boundary: sel=3 is the last legal index
      sel = 4'd3; in_valid = 1'b1;
      tick();
      vectors++; if (out_data !== 64'hF3) begin miscompares++; $display("FAIL bound_sel3 got %h want f3", out_data); end
      vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL bound_sel3_cnt got %0d want 1", err_cnt); end
      // boundary: sel=4 is the first illegal index
      sel = 4'd4;
      tick();
      in_valid = 1'b0;
      vectors++; if (out_data !== 64'h0) begin miscompares++; $display("FAIL bound_sel4 got %h want 0", out_data); end
      vectors++; if (err_cnt !== 8'd2) begin miscompares++; $display("FAIL bound_sel4_cnt got %0d want 2", err_cnt); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL clr_sel_err got %h want 0", sel_err); end
      vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_err_cnt got %0d want 0", err_cnt); end
   endtask

   task automatic test_saturate();
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         sel = SW'(4 + (i % 12));
         tick();
         if (i == 254) begin
            vectors++; if (err_cnt !== 8'd254) begin miscompares++; $display("FAIL sat_254 got %0d want 254", err_cnt); end
         end
         if (i == 256) begin
            vectors++; if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_256 got %0d want 255", err_cnt); end
         end
      end
      vectors++; if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_300 got %0d want 255", err_cnt); end
      sel = 4'd8; err_clr = 1'b1;
      tick();
      err_clr = 1'b0; in_valid = 1'b0;
      vectors++; if (sel_err !== 1'b1) begin miscompares++; $display("FAIL setwins_sel_err got %h want 1", sel_err); end
      vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL setwins_err_cnt got %0d want 1", err_cnt); end
      tick();
   endtask

   task automatic test_reset_mid();
      set_words(64'hB0, 64'hB1, 64'hB2, 64'hB3);
      sel = 4'd5; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      vectors++; if (out_valid !== 1'b1 || sel_err !== 1'b1) begin miscompares++; $display("FAIL mid_setup got valid=%h err=%h want 1/1", out_valid, sel_err); end
      reset = 1'b1; sel = 4'd1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid got %h want 0", out_valid); end
      vectors++; if (out_data !== 64'h0) begin miscompares++; $display("FAIL mid_out_data got %h want 0", out_data); end
      vectors++; if (out_sel !== 4'h0) begin miscompares++; $display("FAIL mid_out_sel got %h want 0", out_sel); end
      vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL mid_sel_err got %h want 0", sel_err); end
      vectors++; if (err_cnt !== 8'h0) begin miscompares++; $display("FAIL mid_err_cnt got %0d want 0", err_cnt); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready got %h want 1", in_ready); end
      // reset with the consumer ready: no transfer completes, word is discarded
      sel = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin miscompares++; $display("FAIL mid_xfer got valid=%h data=%h want 0/0", out_valid, out_data); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_out_of_range();
      test_saturate();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mux_reg_n.md
MUX_REG_N -- requirements
Module: mux_reg_n

Interface
REQ-001 Parameter DATA_W, default 64, width in bits of each data input and of out_data.
REQ-002 Parameter N_IN, default 4, number of data inputs; legal range 2..16.
REQ-003 Parameter SEL_W, default 4, select width; SHALL satisfy 2**SEL_W >= N_IN.
REQ-004 Parameter DFLT, default all-zero DATA_W value, data driven for an out-of-range select.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  N_IN*DATA_W  flattened inputs; input k occupies bits [k*DATA_W +: DATA_W].
REQ-008 sel  input  SEL_W  input index, sampled with in_data on accept.
REQ-009 in_valid  input  1  producer offers in_data/sel this cycle.
REQ-010 in_ready  output  1  block accepts this cycle.
REQ-011 out_data  output  DATA_W  registered selected word.
REQ-012 out_sel  output  SEL_W  registered copy of the sel value that produced out_data.
REQ-013 out_valid  output  1  out_data/out_sel hold an unconsumed word.
REQ-014 out_ready  input  1  consumer takes the word this cycle.
REQ-015 sel_err  output  1  sticky flag, an out-of-range sel was accepted.
REQ-016 err_clr  input  1  clears sel_err.
REQ-017 err_cnt  output  8  saturating count of accepted out-of-range selects.

Function
REQ-018 Accept = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-019 in_ready SHALL be combinational: !out_valid || out_ready (single-entry output register, full throughput).
REQ-020 On accept, next cycle: out_data = word sel when sel < N_IN, else DFLT; out_sel = sel; out_valid = 1.
REQ-021 Latency SHALL be exactly 1 cycle from accept to out_valid.
REQ-022 Transfer out without accept in the same cycle: out_valid -> 0; out_data/out_sel hold their values.
REQ-023 Transfer out with accept in the same cycle: out_valid stays 1, new word loaded, no bubble.
REQ-024 out_valid=1 and out_ready=0: out_data, out_sel, out_valid SHALL hold stable; in_ready=0.
REQ-025 in_valid=0 SHALL never change out_data/out_sel.
REQ-026 Accept with sel >= N_IN: sel_err -> 1 next cycle; err_cnt increments, saturating at 255.
REQ-027 err_clr alone: sel_err -> 0, err_cnt -> 0 next cycle.
REQ-028 err_clr coincident with an out-of-range accept: set wins; sel_err = 1, err_cnt = 1.
REQ-029 Out-of-range sel without accept SHALL not affect sel_err/err_cnt.

Reset
REQ-030 reset SHALL dominate all other inputs in the cycle it is sampled.
REQ-031 Reset values: out_valid 0, out_data 0, out_sel 0, sel_err 0, err_cnt 0.
REQ-032 in_ready SHALL be 1 in the cycle after reset releases (follows REQ-019 from out_valid=0).
REQ-033 Reset mid-transfer SHALL discard the held word; no transfer completes on that edge.

Structure
REQ-034 Package mux_pkg SHALL hold default DATA_W, N_IN, SEL_W and the err_cnt width/saturation constant.
REQ-035 One combinational sub-module mux_n (N_IN:1 select with DFLT for out-of-range) SHALL feed the register stage.
REQ-036 No latches; every always_comb branch SHALL assign all outputs, including out-of-range sel.

Verification
REQ-037 Reset, then sel=2, in_data word2=64'hDEAD_BEEF, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=64'hDEAD_BEEF, out_sel=2.
REQ-038 Back-to-back sel=0,1,2,3, words 10/11/12/13, out_ready=1 -> outputs 10,11,12,13 on consecutive cycles, no bubble.
REQ-039 out_ready=0 for 3 cycles with word 5 held -> in_ready=0, out_data=5 stable; out_ready=1 -> accept resumes next cycle.
REQ-040 Accept sel=7 (N_IN=4) -> out_data=0 (DFLT), sel_err=1, err_cnt=1; err_clr -> both 0.
REQ-041 300 out-of-range accepts -> err_cnt=255; err_clr and out-of-range accept in same cycle -> sel_err=1, err_cnt=1.
REQ-042 reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0, sel_err=0.
